// File: rtl/bpu.sv
// Bimodal branch predictor: a table of saturating direction counters indexed by PC.
// It returns registered predictions, resolves compare-and-branch outcomes and counts mispredicts.
module bpu #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int CNT_W   = 2,
   parameter int STAT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_pred_valid,
   input  logic [XLEN-1:0]   i_pred_pc,
   output logic              o_pred_valid,
   output logic              o_pred_taken,
   input  logic              i_res_valid,
   input  logic [XLEN-1:0]   i_res_pc,
   input  logic [XLEN-1:0]   i_res_a,
   input  logic [XLEN-1:0]   i_res_b,
   input  logic [2:0]        i_res_op,
   input  logic              i_res_pred_taken,
   output logic              o_res_valid,
   output logic              o_res_take,
   output logic              o_res_mispredict,
   output logic [STAT_W-1:0] o_mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);

   localparam logic [2:0] OP_EQ  = 3'd0;
   localparam logic [2:0] OP_NE  = 3'd1;
   localparam logic [2:0] OP_LT  = 3'd2;
   localparam logic [2:0] OP_GE  = 3'd3;
   localparam logic [2:0] OP_LTU = 3'd4;
   localparam logic [2:0] OP_GEU = 3'd5;

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  WEAK_NT  = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   function automatic logic branch_take(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b,
                                        input logic [2:0]      op);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (op)
         OP_EQ:   branch_take = (a == b);
         OP_NE:   branch_take = (a != b);
         OP_LT:   branch_take = (sa < sb);
         OP_GE:   branch_take = (sa >= sb);
         OP_LTU:  branch_take = (a < b);
         OP_GEU:  branch_take = (a >= b);
         default: branch_take = 1'b0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                 input logic             up);
      if (up)
         cnt_step = (c == CNT_MAX) ? c : c + CNT_W'(1);
      else
         cnt_step = (c == '0) ? c : c - CNT_W'(1);
   endfunction

   function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
      stat_inc = (s == STAT_MAX) ? s : s + STAT_W'(1);
   endfunction

   logic [CNT_W-1:0]  table_q [ENTRIES];
   logic [IDX_W-1:0]  pred_idx;
   logic [IDX_W-1:0]  res_idx;
   logic              take_p0;
   logic              mis_p0;

   logic              pred_vld_p1;
   logic              pred_taken_p1;
   logic              res_vld_p1;
   logic              take_p1;
   logic              mis_p1;
   logic [STAT_W-1:0] stat_p1;

   // PC bits outside the index field are intentionally ignored (aliasing allowed).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pred_pc[XLEN-1:IDX_W+2], i_pred_pc[1:0],
                             i_res_pc[XLEN-1:IDX_W+2], i_res_pc[1:0]};

   // Stage p0: index decode and outcome evaluation
   assign pred_idx = i_pred_pc[IDX_W+1:2];
   assign res_idx  = i_res_pc[IDX_W+1:2];
   assign take_p0  = branch_take(i_res_a, i_res_b, i_res_op);
   assign mis_p0   = take_p0 ^ i_res_pred_taken;

   // Stage p1: registered results; the prediction reads the table before this edge's update lands
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pred_vld_p1   <= 1'b0;
         pred_taken_p1 <= 1'b0;
         res_vld_p1    <= 1'b0;
         take_p1       <= 1'b0;
         mis_p1        <= 1'b0;
         stat_p1       <= '0;
         for (int i = 0; i < ENTRIES; i++)
            table_q[i] <= WEAK_NT;
      end else begin
         pred_vld_p1   <= i_pred_valid;
         pred_taken_p1 <= i_pred_valid & table_q[pred_idx][CNT_W-1];
         res_vld_p1    <= i_res_valid;
         take_p1       <= i_res_valid & take_p0;
         mis_p1        <= i_res_valid & mis_p0;
         if (i_res_valid) begin
            table_q[res_idx] <= cnt_step(table_q[res_idx], take_p0);
            if (mis_p0)
               stat_p1 <= stat_inc(stat_p1);
         end
      end
   end

   assign o_pred_valid     = pred_vld_p1;
   assign o_pred_taken     = pred_taken_p1;
   assign o_res_valid      = res_vld_p1;
   assign o_res_take       = take_p1;
   assign o_res_mispredict = mis_p1;
   assign o_mispredict_cnt = stat_p1;

endmodule

// File: tb/tb_bpu.sv
// Directed bench for bpu: a behavioural model checked every cycle plus hand-computed literal checks.
module tb_bpu;

   localparam int XLEN    = 32;
   localparam int ENTRIES = 64;
   localparam int CNT_W   = 2;
   localparam int STAT_W  = 3;

   logic              clk;
   logic              rst;
   logic              pred_valid;
   logic [XLEN-1:0]   pred_pc;
   logic              res_valid;
   logic [XLEN-1:0]   res_pc;
   logic [XLEN-1:0]   res_a;
   logic [XLEN-1:0]   res_b;
   logic [2:0]        res_op;
   logic              res_pred_taken;
   logic              out_pred_valid;
   logic              out_pred_taken;
   logic              out_res_valid;
   logic              out_res_take;
   logic              out_res_mispredict;
   logic [STAT_W-1:0] out_mis_cnt;

   bpu #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_pred_valid     (pred_valid),
      .i_pred_pc        (pred_pc),
      .o_pred_valid     (out_pred_valid),
      .o_pred_taken     (out_pred_taken),
      .i_res_valid      (res_valid),
      .i_res_pc         (res_pc),
      .i_res_a          (res_a),
      .i_res_b          (res_b),
      .i_res_op         (res_op),
      .i_res_pred_taken (res_pred_taken),
      .o_res_valid      (out_res_valid),
      .o_res_take       (out_res_take),
      .o_res_mispredict (out_res_mispredict),
      .o_mispredict_cnt (out_mis_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: counters as plain integers, outcome from the comparison rules.
   int   m_cnt [ENTRIES];
   bit   ready = 0;
   logic e_pv, e_pt, e_rv, e_take, e_mis;
   int   e_stat;

   function automatic bit outcome(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      int          ia = int'(a);
      int          ib = int'(b);
      longint      ua = longint'({32'd0, a});
      longint      ub = longint'({32'd0, b});
      case (op)
         3'd0: return ua == ub;
         3'd1: return ua != ub;
         3'd2: return ia < ib;
         3'd3: return ia >= ib;
         3'd4: return ua < ub;
         3'd5: return ua >= ub;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      int pi, ri, cmax, smax;
      bit t;
      cmax = (1 << CNT_W) - 1;
      smax = (1 << STAT_W) - 1;
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) m_cnt[i] = (1 << (CNT_W - 1)) - 1;
         e_pv = 0; e_pt = 0; e_rv = 0; e_take = 0; e_mis = 0; e_stat = 0;
         ready = 1;
      end else begin
         pi = (pred_pc >> 2) % ENTRIES;
         ri = (res_pc >> 2) % ENTRIES;
         e_pv = pred_valid;
         e_pt = pred_valid && (m_cnt[pi] > cmax / 2);
         t = outcome(res_a, res_b, res_op);
         e_rv = res_valid;
         e_take = res_valid && t;
         e_mis = res_valid && (t != res_pred_taken);
         if (res_valid) begin
            if (t) m_cnt[ri] = (m_cnt[ri] < cmax) ? m_cnt[ri] + 1 : cmax;
            else   m_cnt[ri] = (m_cnt[ri] > 0) ? m_cnt[ri] - 1 : 0;
            if (e_mis && e_stat < smax) e_stat = e_stat + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (ready) begin
         chk("m_pred_valid", {31'd0, out_pred_valid}, {31'd0, e_pv});
         chk("m_pred_taken", {31'd0, out_pred_taken}, {31'd0, e_pt});
         chk("m_res_valid", {31'd0, out_res_valid}, {31'd0, e_rv});
         chk("m_res_take", {31'd0, out_res_take}, {31'd0, e_take});
         chk("m_res_mispredict", {31'd0, out_res_mispredict}, {31'd0, e_mis});
         chk("m_mis_cnt", {29'd0, out_mis_cnt}, e_stat);
      end
   end

   task automatic drive(input bit pv, input logic [31:0] ppc, input bit rv, input logic [31:0] rpc,
                        input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input bit pt, input bit r);
      pred_valid = pv; pred_pc = ppc; res_valid = rv; res_pc = rpc;
      res_a = a; res_b = b; res_op = op; res_pred_taken = pt; rst = r;
      @(posedge clk);
      #1;
      pred_valid = 0; pred_pc = 0; res_valid = 0; res_pc = 0;
      res_a = 0; res_b = 0; res_op = 0; res_pred_taken = 0; rst = 0;
   endtask

   task automatic pred(input logic [31:0] pc);
      drive(1, pc, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic res(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input bit pt);
      drive(0, 0, 1, pc, a, b, op, pt, 0);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pred_valid = 0; pred_pc = 0; res_valid = 0; res_pc = 0;
      res_a = 0; res_b = 0; res_op = 0; res_pred_taken = 0; rst = 1;
      do_reset();
      do_reset();
      chk("rst_pred_valid", {31'd0, out_pred_valid}, 0);
      chk("rst_pred_taken", {31'd0, out_pred_taken}, 0);
      chk("rst_res_valid", {31'd0, out_res_valid}, 0);
      chk("rst_res_take", {31'd0, out_res_take}, 0);
      chk("rst_res_mis", {31'd0, out_res_mispredict}, 0);
      chk("rst_cnt", {29'd0, out_mis_cnt}, 0);

      pred(32'h100);
      chk("first_pred_valid", {31'd0, out_pred_valid}, 1);
      chk("first_pred_taken", {31'd0, out_pred_taken}, 0);

      res(32'h100, 5, 5, 3'd0, 0);
      chk("eq_valid", {31'd0, out_res_valid}, 1);
      chk("eq_take", {31'd0, out_res_take}, 1);
      chk("eq_mis", {31'd0, out_res_mispredict}, 1);
      chk("eq_cnt", {29'd0, out_mis_cnt}, 1);
      pred(32'h100);
      chk("pred_100_trained", {31'd0, out_pred_taken}, 1);
      pred(32'h200);
      chk("pred_200_alias", {31'd0, out_pred_taken}, 1);

      res(32'h10, 32'hFFFF_FFFF, 1, 3'd2, 0);
      chk("lt_take", {31'd0, out_res_take}, 1);
      res(32'h10, 32'hFFFF_FFFF, 1, 3'd4, 0);
      chk("ltu_take", {31'd0, out_res_take}, 0);
      res(32'h10, 32'hFFFF_FFFF, 1, 3'd3, 0);
      chk("ge_take", {31'd0, out_res_take}, 0);
      res(32'h10, 32'hFFFF_FFFF, 1, 3'd5, 0);
      chk("geu_take", {31'd0, out_res_take}, 1);
      res(32'h10, 32'hFFFF_FFFF, 1, 3'd6, 0);
      chk("op6_take", {31'd0, out_res_take}, 0);
      res(32'h10, 7, 7, 3'd1, 0);
      chk("ne_equal_take", {31'd0, out_res_take}, 0);
      res(32'h10, 7, 7, 3'd7, 1);
      chk("op7_take", {31'd0, out_res_take}, 0);
      chk("op7_mis", {31'd0, out_res_mispredict}, 1);
      chk("ops_cnt", {29'd0, out_mis_cnt}, 4);

      for (int i = 0; i < 4; i++) res(32'h20, 1, 2, 3'd0, 1);
      chk("stat_saturate", {29'd0, out_mis_cnt}, 7);
      drive(0, 0, 0, 32'h20, 1, 2, 3'd0, 1, 0);
      chk("idle_res_valid", {31'd0, out_res_valid}, 0);
      chk("idle_res_mis", {31'd0, out_res_mispredict}, 0);
      chk("idle_cnt", {29'd0, out_mis_cnt}, 7);

      do_reset();
      for (int i = 0; i < 4; i++) res(32'h100, 0, 0, 3'd0, 1);
      pred(32'h100);
      chk("sat3_pred", {31'd0, out_pred_taken}, 1);
      res(32'h100, 0, 0, 3'd1, 1);
      pred(32'h103);
      chk("cnt2_pred", {31'd0, out_pred_taken}, 1);
      res(32'h100, 0, 0, 3'd1, 1);
      res(32'h100, 0, 0, 3'd1, 1);
      pred(32'h100);
      chk("cnt0_pred", {31'd0, out_pred_taken}, 0);
      chk("train_cnt", {29'd0, out_mis_cnt}, 3);

      do_reset();
      drive(1, 32'h104, 1, 32'h104, 0, 0, 3'd0, 0, 0);
      chk("rbw_pred", {31'd0, out_pred_taken}, 0);
      chk("rbw_take", {31'd0, out_res_take}, 1);
      pred(32'h104);
      chk("rbw_after", {31'd0, out_pred_taken}, 1);

      do_reset();
      res(32'h100, 0, 0, 3'd0, 0);
      res(32'h100, 0, 0, 3'd0, 0);
      chk("pre_rst_cnt", {29'd0, out_mis_cnt}, 2);
      drive(1, 32'h100, 1, 32'h100, 1, 2, 3'd0, 1, 1);
      chk("midrst_pred_valid", {31'd0, out_pred_valid}, 0);
      chk("midrst_pred_taken", {31'd0, out_pred_taken}, 0);
      chk("midrst_res_valid", {31'd0, out_res_valid}, 0);
      chk("midrst_res_take", {31'd0, out_res_take}, 0);
      chk("midrst_res_mis", {31'd0, out_res_mispredict}, 0);
      chk("midrst_cnt", {29'd0, out_mis_cnt}, 0);
      pred(32'h100);
      chk("post_rst_pred", {31'd0, out_pred_taken}, 0);
      chk("post_rst_cnt", {29'd0, out_mis_cnt}, 0);

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
